alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Issue controller that sits between the decode stage and the ALU/ALU-control path of the MIPS datapath.
- Accepts one R-type instruction at a time via valid/ready, decodes funct to the 4-bit ALU op code, and drives a start pulse to the ALU.
- Holds the op stable for the op's latency (1 cycle for simple ops, multi-cycle for MUL/DIV), then presents completion to writeback via valid/ready.
- Supports back-to-back issue and pipeline flush.

Parameters:
- MUL_LAT, 4, cycles the ALU needs for MUL (legal range 1..2^CNT_W-1).
- DIV_LAT, 32, cycles the ALU needs for DIV (legal range 1..2^CNT_W-1).
- CNT_W, 6, width of the latency down-counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  sequencer can accept this cycle (combinational).
- funct  in  6  instruction funct field.
- flush  in  1  synchronous abort of the in-flight op.
- alu_op  out  4  registered ALU op code, stable for the whole op.
- alu_start  out  1  one-cycle pulse, first cycle of each op.
- busy  out  1  state != IDLE.
- out_valid  out  1  op result complete.
- out_ready  in  1  writeback accepts the result.
- illegal  out  1  registered; accompanies out_valid, set when funct was unrecognised.

Behaviour:
- Decode (funct -> alu_op):
  - 100000->0000 ADD
  - 100010->0001 SUB
  - 000010->0010 MUL
  - 011010->0011 DIV
  - 100100->0100 AND
  - 100101->0101 OR
  - 100111->0110 NOR
  - 000000->0111 SLL
  - 000011->1000 SRL
  - 101010->1001 SLT
  - 100110->1010 XOR
  - Any other funct -> 0000 with illegal=1, latency 1.
- Latency LAT per op: MUL=MUL_LAT, DIV=DIV_LAT, all others 1.
- Reset (rst_n=0, immediate, asynchronous):
  - state=IDLE, alu_op=0000, alu_start=0, out_valid=0, illegal=0, counter=0.
  - Any in-flight op is dropped with no completion.
- States: IDLE, EXEC, DONE.
- Accept: occurs at the rising edge where in_valid && in_ready.
  - in_ready = !flush && (state==IDLE || (state==DONE && out_ready)).
  - On accept, register alu_op/illegal, load counter=LAT-1, assert alu_start for the next cycle only, and go to EXEC.
- EXEC:
  - alu_op held.
  - If counter==0: go to DONE and assert out_valid next cycle; otherwise decrement.
  - Accept-edge to out_valid-rise is exactly LAT+1 cycles.
- DONE:
  - out_valid=1 and alu_op held until out_ready.
  - On out_ready: if in_valid is present in the same cycle, accept it (back-to-back, no bubble: out_valid falls, alu_start rises next cycle, state EXEC). Otherwise go to IDLE and drop out_valid.
- Flush (highest priority after reset):
  - Next edge: state=IDLE, out_valid=0, alu_start=0, illegal=0, counter=0.
  - alu_op keeps its last value.
  - in_ready=0 during the flush cycle, so no accept occurs.
- alu_start is never asserted in IDLE or DONE, and never for two consecutive cycles within one op.
- Counter never wraps: loaded only on accept, decremented only in EXEC when nonzero.
- out_valid with out_ready=0 is held indefinitely; alu_op and illegal do not change while out_valid=1.

Test Plan:
- Reset then ADD: release rst_n, funct=100000 accepted at edge 0 -> alu_op=0000 and alu_start=1 in cycle 1; out_valid=1 in cycle 2; illegal=0; busy=1 cycles 1..2.
- MUL latency (MUL_LAT=4): funct=000010 accepted at edge 0 -> alu_op=0010; alu_start high in cycle 1 only; out_valid rises in cycle 5. DIV (DIV_LAT=32): funct=011010 -> alu_op=0011, out_valid rises in cycle 33.
- Back-pressure and back-to-back: SUB completes with out_ready=0 for 3 cycles -> out_valid, alu_op=0001 held, in_ready=0. Then out_ready=1 with in_valid=1, funct=100110 -> next cycle alu_op=1010, alu_start=1, out_valid=0.
- Illegal funct: funct=111111 -> alu_op=0000, out_valid two cycles after accept with illegal=1. Next legal op completes with illegal=0.
- Flush mid-DIV: assert flush at cycle 10 of DIV -> next cycle busy=0, out_valid never rises, in_ready=1. A following OR (100101) completes normally with alu_op=0101.
- Async reset mid-MUL: pull rst_n low between edges in cycle 3 -> outputs go to reset values immediately without a clock edge. No out_valid after rst_n is released.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue controller between MIPS decode and the ALU. Takes one R-type
//   instruction at a time over a valid/ready handshake, decodes funct into
//   the 4-bit ALU op code, pulses alu_start on the first cycle of the op,
//   holds the op for its latency (MUL/DIV are multi-cycle) and then offers
//   completion to writeback over a second valid/ready handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   decode presents an instruction
//   in_ready   out  sequencer can accept this cycle (combinational)
//   funct      in   [5:0] instruction funct field
//   flush      in   synchronous abort of the in-flight op
//   alu_op     out  [3:0] registered ALU op code, stable for the whole op
//   alu_start  out  one-cycle pulse on the first cycle of each op
//   busy       out  sequencer is not idle
//   out_valid  out  op result complete
//   out_ready  in   writeback accepts the result
//   illegal    out  registered; set with out_valid when funct was unknown
module alu_op_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] funct,
  input  logic       flush,
  output logic [3:0] alu_op,
  output logic       alu_start,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0]       OP_MUL  = 4'b0010;
  localparam logic [3:0]       OP_DIV  = 4'b0011;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Returns {illegal, op}. Unknown functs map to ADD's code so the ALU
  // still sees a harmless single-cycle op.
  function automatic logic [4:0] decode_funct(input logic [5:0] f);
    case (f)
      6'b100000: decode_funct = {1'b0, 4'b0000};
      6'b100010: decode_funct = {1'b0, 4'b0001};
      6'b000010: decode_funct = {1'b0, 4'b0010};
      6'b011010: decode_funct = {1'b0, 4'b0011};
      6'b100100: decode_funct = {1'b0, 4'b0100};
      6'b100101: decode_funct = {1'b0, 4'b0101};
      6'b100111: decode_funct = {1'b0, 4'b0110};
      6'b000000: decode_funct = {1'b0, 4'b0111};
      6'b000011: decode_funct = {1'b0, 4'b1000};
      6'b101010: decode_funct = {1'b0, 4'b1001};
      6'b100110: decode_funct = {1'b0, 4'b1010};
      default:   decode_funct = {1'b1, 4'b0000};
    endcase
  endfunction

  // Counter preload is latency-1: the counter hits zero on the last
  // execute cycle, and out_valid rises on the following edge.
  function automatic logic [CNT_W-1:0] preload(input logic [3:0] op);
    case (op)
      OP_MUL:  preload = MUL_CNT;
      OP_DIV:  preload = DIV_CNT;
      default: preload = '0;
    endcase
  endfunction

  logic [3:0] dec_op;
  logic       dec_ill;
  logic       accept;

  assign {dec_ill, dec_op} = decode_funct(funct);
  assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_op    <= 4'b0000;
      alu_start <= 1'b0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
    end else if (flush) begin
      // alu_op deliberately keeps its last value across a flush.
      state     <= IDLE;
      alu_start <= 1'b0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
    end else begin
      alu_start <= 1'b0;
      // accept is only possible from IDLE or from DONE with out_ready,
      // which covers both fresh issue and bubble-free back-to-back issue.
      if (accept) begin
        state     <= EXEC;
        alu_op    <= dec_op;
        illegal   <= dec_ill;
        cnt       <= preload(dec_op);
        alu_start <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        case (state)
          EXEC: begin
            if (cnt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DONE: begin
            if (out_ready) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 6;
  localparam int TMO     = DIV_LAT + 8;

  // Funct values in op-code order: the index of a funct is its op code.
  localparam logic [5:0] LEGAL_F [11] = '{
    6'b100000, 6'b100010, 6'b000010, 6'b011010, 6'b100100, 6'b100101,
    6'b100111, 6'b000000, 6'b000011, 6'b101010, 6'b100110};

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, flush, alu_start, busy;
  logic       out_valid, out_ready, illegal;
  logic [5:0] funct;
  logic [3:0] alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .flush(flush), .alu_op(alu_op), .alu_start(alu_start),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .illegal(illegal));

  // Reference model: table lookup for op code, latency from op identity.
  function automatic void ref_decode(input logic [5:0] f, output logic [3:0] op,
                                     output logic ill, output int lat);
    op = 4'b0000; ill = 1'b1; lat = 1;
    for (int i = 0; i < 11; i++)
      if (LEGAL_F[i] == f) begin
        op  = 4'(i);
        ill = 1'b0;
        lat = (i == 2) ? MUL_LAT : (i == 3) ? DIV_LAT : 1;
      end
  endfunction

  function automatic logic [5:0] rand_funct();
    if ($urandom_range(0, 3) != 0) return LEGAL_F[$urandom_range(0, 10)];
    return 6'($urandom);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; funct = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (alu_op !== 4'b0000) begin n_fail++; $display("FAIL reset_alu_op got=%b exp=0000", alu_op); end
    n_checks++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL reset_alu_start got=%b exp=0", alu_start); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
  endtask

  // Each op issued from idle, completed with a random stall, then idle again.
  task automatic test_single_ops();
    logic [5:0] fq[$];
    logic [3:0] eop;
    logic       eill;
    int         lat, cyc, stall;
    fq = '{6'b100000, 6'b000010, 6'b011010, 6'b111111, 6'b100000};
    repeat (10) fq.push_back(rand_funct());
    foreach (fq[i]) begin
      ref_decode(fq[i], eop, eill, lat);
      stall = (i < 5) ? i % 3 : $urandom_range(0, 3);
      @(negedge clk);
      in_valid = 1'b1; funct = fq[i]; out_ready = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready f=%b got=%b exp=1", fq[i], in_ready); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL single_start f=%b got=%b exp=1", fq[i], alu_start); end
      n_checks++; if (alu_op !== eop) begin n_fail++; $display("FAIL single_op f=%b got=%b exp=%b", fq[i], alu_op, eop); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy f=%b got=%b exp=1", fq[i], busy); end
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < TMO) begin
        @(negedge clk);
        cyc++;
        n_checks++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL single_start_extra f=%b cycle=%0d got=%b exp=0", fq[i], cyc, alu_start); end
      end
      n_checks++; if (cyc != lat + 1) begin n_fail++; $display("FAIL single_latency f=%b got=%0d exp=%0d", fq[i], cyc, lat + 1); end
      n_checks++; if (illegal !== eill) begin n_fail++; $display("FAIL single_illegal f=%b got=%b exp=%b", fq[i], illegal, eill); end
      n_checks++; if (alu_op !== eop) begin n_fail++; $display("FAIL single_op_done f=%b got=%b exp=%b", fq[i], alu_op, eop); end
      repeat (stall) begin
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || alu_op !== eop || illegal !== eill || in_ready !== 1'b0)
          begin n_fail++; $display("FAIL single_hold f=%b got=v%b op%b il%b rdy%b exp=v1 op%b il%b rdy0", fq[i], out_valid, alu_op, illegal, in_ready, eop, eill); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release f=%b got=v%b busy%b exp=v0 busy0", fq[i], out_valid, busy); end
    end
  endtask

  // Chain of ops where each completion handshake carries the next issue.
  task automatic test_back_to_back();
    logic [5:0] fq[$];
    int         sq[$];
    logic [3:0] eop;
    logic       eill;
    int         lat, cyc;
    fq = '{6'b100010, 6'b100110};
    sq = '{3, 0};
    repeat (6) begin fq.push_back(rand_funct()); sq.push_back($urandom_range(0, 2)); end
    @(negedge clk);
    in_valid = 1'b1; funct = fq[0]; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    foreach (fq[i]) begin
      ref_decode(fq[i], eop, eill, lat);
      n_checks++; if (alu_start !== 1'b1 || alu_op !== eop || out_valid !== 1'b0)
        begin n_fail++; $display("FAIL b2b_issue idx=%0d got=s%b op%b v%b exp=s1 op%b v0", i, alu_start, alu_op, out_valid, eop); end
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < TMO) begin
        @(negedge clk);
        cyc++;
      end
      n_checks++; if (cyc != lat + 1) begin n_fail++; $display("FAIL b2b_latency idx=%0d got=%0d exp=%0d", i, cyc, lat + 1); end
      n_checks++; if (illegal !== eill) begin n_fail++; $display("FAIL b2b_illegal idx=%0d got=%b exp=%b", i, illegal, eill); end
      for (int s = 0; s < sq[i]; s++) begin
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || alu_op !== eop || in_ready !== 1'b0)
          begin n_fail++; $display("FAIL b2b_hold idx=%0d got=v%b op%b rdy%b exp=v1 op%b rdy0", i, out_valid, alu_op, in_ready, eop); end
      end
      out_ready = 1'b1;
      if (i + 1 < fq.size()) begin in_valid = 1'b1; funct = fq[i + 1]; end
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready idx=%0d got=%b exp=1", i, in_ready); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
    end
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=busy%b v%b exp=busy0 v0", busy, out_valid); end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; funct = 6'b011010;
    @(posedge clk);
    @(negedge clk);                      // cycle 1 of DIV
    in_valid = 1'b0;
    repeat (9) @(negedge clk);           // cycle 10
    flush = 1'b1; in_valid = 1'b1; funct = 6'b100000;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || alu_start !== 1'b0 || illegal !== 1'b0)
      begin n_fail++; $display("FAIL flush_state got=busy%b v%b s%b il%b exp=all0", busy, out_valid, alu_start, illegal); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after got=%b exp=1", in_ready); end
    n_checks++; if (alu_op !== 4'b0011) begin n_fail++; $display("FAIL flush_alu_op_kept got=%b exp=0011", alu_op); end
    seen = 0;
    repeat (DIV_LAT + 4) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_out_valid got=%0d exp=0", seen); end
    in_valid = 1'b1; funct = 6'b100101;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (alu_start !== 1'b1 || alu_op !== 4'b0101) begin n_fail++; $display("FAIL flush_or_issue got=s%b op%b exp=s1 op0101", alu_start, alu_op); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL flush_or_done got=v%b il%b exp=v1 il0", out_valid, illegal); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_or_release got=%b exp=0", busy); end
  endtask

  task automatic test_async_reset();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; funct = 6'b000010;
    @(posedge clk);
    @(negedge clk);                      // cycle 1 of MUL
    in_valid = 1'b0;
    n_checks++; if (alu_op !== 4'b0010) begin n_fail++; $display("FAIL areset_mul_op got=%b exp=0010", alu_op); end
    repeat (2) @(negedge clk);           // cycle 3
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (alu_op !== 4'b0000 || alu_start !== 1'b0 || out_valid !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL areset_immediate got=op%b s%b v%b il%b busy%b exp=op0000 all0", alu_op, alu_start, out_valid, illegal, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge clk); if (out_valid === 1'b1 || busy === 1'b1) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL areset_no_completion got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
